// File: rtl/fa_4_pkg.sv
// Shared constants for the fa_4 ripple-carry add cell.
package fa_4_pkg;
    localparam int FA_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/fa_4_full_adder_1b.sv
// One-bit full adder: the ripple stage of fa_4.
// Latency: combinational, 0 cycles.
// Backpressure: none; a pure function of its inputs.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/fa_4.sv
// Registered unsigned ripple-carry adder: {cout, s} = a + b + cin.
// Latency: 1 cycle from operands to s/cout; synchronous reset clears both.
// Backpressure: none; operands are consumed on every clock edge.
module fa_4
    import fa_4_pkg::*;
#(
    parameter int DATA_WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  cout
);
    logic [DATA_WIDTH:0]   carry;
    logic [DATA_WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    // Carry ripples LSB to MSB; carry[DATA_WIDTH] is the 2^DATA_WIDTH weight bit.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        full_adder_1b u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum_comb;
            cout <= carry[DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_fa_4.sv
// Bench for fa_4: directed test-plan vectors, exhaustive 4-bit sweep, random 1/8-bit runs.
module tb_fa_4;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0] a4 = '0, b4 = '0, s4;
    logic       cin4 = 1'b0, cout4;
    logic [0:0] a1 = '0, b1 = '0, s1;
    logic       cin1 = 1'b0, cout1;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       cin8 = 1'b0, cout8;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
    } vec_t;

    always #5 clk = ~clk;

    fa_4 #(.DATA_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .s(s4), .cout(cout4));
    fa_4 #(.DATA_WIDTH(1)) dut1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1), .cout(cout1));
    fa_4 #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .s(s8), .cout(cout8));

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({cout4, s4} !== 5'b0_0000) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b/%b want 0000/0", i, s4, cout4);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({cout4, s4} !== 5'b1_1111) begin
            n_fail++;
            $display("FAIL reset_release: got %b/%b want 1111/1", s4, cout4);
        end
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0});
        v.push_back('{4'b0000, 4'b0100, 1'b0, 4'b0100, 1'b0});
        v.push_back('{4'b0010, 4'b0110, 1'b0, 4'b1000, 1'b0});
        v.push_back('{4'b0011, 4'b0111, 1'b0, 4'b1010, 1'b0});
        v.push_back('{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1});
        v.push_back('{4'b1010, 4'b1011, 1'b0, 4'b0101, 1'b1});
        v.push_back('{4'b0110, 4'b1110, 1'b0, 4'b0100, 1'b1});
        v.push_back('{4'b1110, 4'b1101, 1'b0, 4'b1011, 1'b1});
        v.push_back('{4'b1010, 4'b1110, 1'b0, 4'b1000, 1'b1});
        v.push_back('{4'b0111, 4'b1000, 1'b1, 4'b0000, 1'b1});
        v.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0});
        foreach (v[i]) begin
            a4 = v[i].a; b4 = v[i].b; cin4 = v[i].ci;
            tick();
            n_cmp++;
            if (s4 !== v[i].s || cout4 !== v[i].co) begin
                n_fail++;
                $display("FAIL directed[%0d] %b+%b+%b: got %b/%b want %b/%b",
                         i, v[i].a, v[i].b, v[i].ci, s4, cout4, v[i].s, v[i].co);
            end
        end
    endtask

    // Three consecutive adds; outputs must lag inputs by exactly one edge.
    // With mid_rst the middle edge is a reset edge and its operands are dropped.
    task automatic test_back_to_back(input bit mid_rst);
        logic [3:0] ta [3] = '{4'b1000, 4'b0101, 4'b0010};
        logic [3:0] tb [3] = '{4'b1001, 4'b0110, 4'b1011};
        logic [4:0] want [3];
        logic [4:0] prev;
        want[0] = 5'b1_0001;
        want[1] = mid_rst ? 5'b0_0000 : 5'b0_1011;
        want[2] = 5'b0_1101;
        cin4 = 1'b0; a4 = 4'b0000; b4 = 4'b0001;
        tick();
        prev = {cout4, s4};
        for (int i = 0; i < 3; i++) begin
            a4 = ta[i]; b4 = tb[i];
            rst = mid_rst && (i == 1);
            #2;
            n_cmp++;
            if ({cout4, s4} !== prev) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d] rst=%0b: got %b before edge want %b", i, mid_rst, {cout4, s4}, prev);
            end
            tick();
            n_cmp++;
            if ({cout4, s4} !== want[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d] rst=%0b: got %b/%b want %b/%b",
                         i, mid_rst, s4, cout4, want[i][3:0], want[i][4]);
            end
            prev = want[i];
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive();
        int e;
        int bad = 0;
        for (int k = 0; k < 512; k++) begin
            a4 = k[3:0]; b4 = k[7:4]; cin4 = k[8];
            e = int'(a4) + int'(b4) + int'(cin4);
            tick();
            n_cmp++;
            if ({cout4, s4} !== 5'(e)) begin
                n_fail++;
                bad++;
                if (bad <= 8)
                    $display("FAIL exhaustive %h+%h+%b: got %b want %b", a4, b4, cin4, {cout4, s4}, 5'(e));
            end
        end
    endtask

    // Random operands at widths 1 and 8, expected sums queued and retired one edge later.
    task automatic test_random_widths(input int n);
        int q1[$];
        int q8[$];
        int e;
        for (int k = 0; k < n; k++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            q1.push_back(int'(a1) + int'(b1) + int'(cin1));
            q8.push_back(int'(a8) + int'(b8) + int'(cin8));
            tick();
            e = q1.pop_front();
            n_cmp++;
            if ({cout1, s1} !== 2'(e)) begin
                n_fail++;
                $display("FAIL rand_w1[%0d]: got %b want %b", k, {cout1, s1}, 2'(e));
            end
            e = q8.pop_front();
            n_cmp++;
            if ({cout8, s8} !== 9'(e)) begin
                n_fail++;
                $display("FAIL rand_w8[%0d]: got %h want %h", k, {cout8, s8}, 9'(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_exhaustive();
        test_random_widths(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
